// File: rtl/mult_2_bit_arbiter.sv
// Round-robin arbiter that shares one external 2x2-bit multiplier among N_REQ
// requesters and returns each product with its owner's ID on a response channel.
module mult_2_bit_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [2*N_REQ-1:0]   a_in,
  input  logic [2*N_REQ-1:0]   b_in,
  output logic [N_REQ-1:0]     gnt,
  output logic [1:0]           mul_a,
  output logic [1:0]           mul_b,
  input  logic [3:0]           mul_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [3:0]           rsp_p,
  output logic                 busy,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    last_id_q, last_id_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [1:0]         mul_a_q, mul_a_d;
  logic [1:0]         mul_b_q, mul_b_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [3:0]         rsp_p_q, rsp_p_d;
  logic               busy_q, busy_d;

  logic               sel_found;
  logic [ID_W-1:0]    sel_id;
  logic [ID_W-1:0]    cand;

  // Response channel: a response transfers on a rising edge where rsp_valid and
  // rsp_ready are both high; once raised, rsp_valid and its payload stay frozen
  // until that edge, and rsp_ready may be driven freely by the consumer.
  logic rsp_fire;
  assign rsp_fire = rsp_valid_q && rsp_ready;

  // Walk candidates from last_id+N_REQ down to last_id+1 so the nearest set bit
  // above the previous winner is the one left standing.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last_id_q) + k) % N_REQ);
      if (req[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sel_found) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_id_d   = last_id_q;
    gnt_d       = '0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
    busy_d      = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          gnt_d     = N_REQ'(1) << sel_id;
          mul_a_d   = a_in[{sel_id, 1'b0} +: 2];
          mul_b_d   = b_in[{sel_id, 1'b0} +: 2];
          rsp_id_d  = sel_id;
          last_id_d = sel_id;
        end
      end
      ISSUE: begin
        rsp_p_d     = mul_p;
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        if (rsp_fire) rsp_valid_d = 1'b0;
      end
      default: begin
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_id_q   <= ID_W'(N_REQ - 1);
      gnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      last_id_q   <= last_id_d;
      gnt_q       <= gnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt         = gnt_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_p       = rsp_p_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mult_2_bit_arbiter.sv
// Bench for mult_2_bit_arbiter: plays the requesters, the multiplier and the
// response consumer, and scoreboards every response against queued expectations.
module tb_mult_2_bit_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N_REQ-1:0]    req = '0;
  logic [2*N_REQ-1:0]  a_in = '0;
  logic [2*N_REQ-1:0]  b_in = '0;
  logic [N_REQ-1:0]    gnt;
  logic [1:0]          mul_a;
  logic [1:0]          mul_b;
  logic [3:0]          mul_p;
  logic                rsp_valid;
  logic                rsp_ready = 1'b1;
  logic [ID_W-1:0]     rsp_id;
  logic [3:0]          rsp_p;
  logic                busy;
  logic [1:0]          dbg_state;

  int checks   = 0;
  int failures = 0;
  int waited;

  logic [ID_W+3:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  // the shared combinational multiplier
  assign mul_p = {2'b00, mul_a} * {2'b00, mul_b};

  mult_2_bit_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .gnt        (gnt),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_p      (rsp_p),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // driver tasks: inputs change and direct checks happen 1 time unit after posedge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input int a, input int b);
    a_in[2*id +: 2] = 2'(a);
    b_in[2*id +: 2] = 2'(b);
  endtask

  task automatic push_exp(input int id, input int a, input int b);
    exp_q.push_back({ID_W'(id), 4'(a * b)});
  endtask

  task automatic wait_gnt(input int exp_id, output int n);
    n = 0;
    do begin
      next_cycle();
      n++;
    end while (gnt == '0 && n < 30);
    check("gnt_seen", 32'(gnt != '0), 1);
    check("gnt_id", 32'(gnt), 32'(1 << exp_id));
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      next_cycle();
    end
    check("drain_q", exp_q.size(), 0);
    check("drain_busy", 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    rsp_ready = 1'b1;
    next_cycle();
    next_cycle();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 0);
    check({tag, "_mul_a"}, 32'(mul_a), 0);
    check({tag, "_mul_b"}, 32'(mul_b), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 0);
    check({tag, "_rsp_p"}, 32'(rsp_p), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_state"}, 32'(dbg_state), 0);
  endtask

  // scoreboard: every completed handshake pops one expected {id, product}
  logic [ID_W+3:0] exp_e;
  always @(negedge clk) begin
    if (rst_n) begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 1);
      check("busy_vs_state", 32'(busy), 32'(dbg_state != 2'd0));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          exp_e = exp_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(exp_e[ID_W+3:4]));
          check("rsp_p", 32'(rsp_p), 32'(exp_e[3:0]));
        end
      end
    end
  end

  initial begin
    // reset state
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    check_zero_outputs("reset");
    do_reset();

    // single requester, 3x3 with exact timing
    set_ops(0, 3, 3);
    req = 4'b0001;
    push_exp(0, 3, 3);
    next_cycle();
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_mul_a", 32'(mul_a), 3);
    check("single_mul_b", 32'(mul_b), 3);
    req = '0;
    next_cycle();
    check("single_gnt_pulse", 32'(gnt), 0);
    check("single_valid", 32'(rsp_valid), 1);
    check("single_p", 32'(rsp_p), 9);
    check("single_id", 32'(rsp_id), 0);
    next_cycle();
    check("single_valid_done", 32'(rsp_valid), 0);
    drain();

    // simultaneous requests, grants 0..3 three cycles apart
    do_reset();
    set_ops(0, 1, 2);
    set_ops(1, 2, 3);
    set_ops(2, 3, 1);
    set_ops(3, 2, 2);
    push_exp(0, 1, 2);
    push_exp(1, 2, 3);
    push_exp(2, 3, 1);
    push_exp(3, 2, 2);
    req = 4'b1111;
    for (int id = 0; id < N_REQ; id++) begin
      wait_gnt(id, waited);
      check("simul_spacing", waited, (id == 0) ? 1 : 3);
      req[id] = 1'b0;
    end
    drain();

    // round-robin fairness: after 2, requester 3 wins over 0
    do_reset();
    set_ops(2, 1, 3);
    push_exp(2, 1, 3);
    req = 4'b0100;
    wait_gnt(2, waited);
    set_ops(3, 3, 3);
    set_ops(0, 2, 1);
    push_exp(3, 3, 3);
    push_exp(0, 2, 1);
    req = 4'b1001;
    wait_gnt(3, waited);
    check("rr_spacing", waited, 3);
    req[3] = 1'b0;
    wait_gnt(0, waited);
    req = '0;
    drain();

    // backpressure: 2x3 held for 5 cycles with another request pending
    do_reset();
    rsp_ready = 1'b0;
    set_ops(1, 2, 3);
    push_exp(1, 2, 3);
    req = 4'b0010;
    wait_gnt(1, waited);
    check("bp_mul_a", 32'(mul_a), 2);
    check("bp_mul_b", 32'(mul_b), 3);
    set_ops(2, 1, 1);
    req = 4'b0100;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_p", 32'(rsp_p), 6);
      check("bp_id", 32'(rsp_id), 1);
      check("bp_hold_a", 32'(mul_a), 2);
      check("bp_hold_b", 32'(mul_b), 3);
      check("bp_no_gnt", 32'(gnt), 0);
      next_cycle();
    end
    push_exp(2, 1, 1);
    rsp_ready = 1'b1;
    next_cycle();
    check("bp_released", 32'(rsp_valid), 0);
    next_cycle();
    check("bp_next_gnt", 32'(gnt), 32'h4);
    req = '0;
    drain();

    // reset while a response is pending
    do_reset();
    rsp_ready = 1'b0;
    set_ops(0, 1, 1);
    req = 4'b0001;
    wait_gnt(0, waited);
    req = '0;
    next_cycle();
    check("mid_valid", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    next_cycle();
    check_zero_outputs("mid_reset");
    set_ops(1, 3, 2);
    set_ops(2, 1, 1);
    set_ops(3, 1, 1);
    push_exp(1, 3, 2);
    rsp_ready = 1'b1;
    req = 4'b1110;
    rst_n = 1'b1;
    wait_gnt(1, waited);
    check("mid_first_gnt_latency", waited, 1);
    req = '0;
    drain();

    // exhaustive operand sweep on requester 2
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        set_ops(2, a, b);
        push_exp(2, a, b);
        req = 4'b0100;
        wait_gnt(2, waited);
        req = '0;
        drain();
      end
    end

    // a few random single requests
    for (int t = 0; t < 8; t++) begin
      int id, a, b;
      id = $urandom_range(0, N_REQ - 1);
      a  = $urandom_range(0, 3);
      b  = $urandom_range(0, 3);
      set_ops(id, a, b);
      push_exp(id, a, b);
      req = N_REQ'(1) << id;
      wait_gnt(id, waited);
      req = '0;
      drain();
    end

    check("final_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
